// File: rtl/branch_resolve_ctrl_if.sv
// Handshake bundle between ID decode/hazard logic (master) and the branch resolve controller (slave).
// With BR_STAT_EN defined, the bundle also carries the retired/taken branch counters.
interface branch_resolve_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              br_valid;
  logic              br_is_bne;
  logic [ADDR_W-1:0] br_pc;
  logic [15:0]       br_offset;
  logic              opnd_ready;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              stall;
  logic              br_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              wait_err;
`ifdef BR_STAT_EN
  logic [31:0]       br_cnt;
  logic [31:0]       taken_cnt;

  modport master (
    output br_valid, br_is_bne, br_pc, br_offset, opnd_ready, rdata1, rdata2,
    input  stall, br_ready, redirect, redirect_pc, wait_err, br_cnt, taken_cnt
  );
  modport slave (
    input  br_valid, br_is_bne, br_pc, br_offset, opnd_ready, rdata1, rdata2,
    output stall, br_ready, redirect, redirect_pc, wait_err, br_cnt, taken_cnt
  );
`else
  modport master (
    output br_valid, br_is_bne, br_pc, br_offset, opnd_ready, rdata1, rdata2,
    input  stall, br_ready, redirect, redirect_pc, wait_err
  );
  modport slave (
    input  br_valid, br_is_bne, br_pc, br_offset, opnd_ready, rdata1, rdata2,
    output stall, br_ready, redirect, redirect_pc, wait_err
  );
`endif
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage BEQ/BNE resolver: waits for operands, registers compare + target, pulses redirect.
// Optional BR_STAT_EN adds br_cnt/taken_cnt statistics counters.
//
//   state   | meaning
//   IDLE    | no branch in flight; accepts a new one
//   WAIT    | branch held, operands not yet forwarded
//   RESOLVE | result registered; br_ready, redirect if taken
module branch_resolve_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  branch_resolve_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;
  logic              latch;
  logic              taken, taken_q;
  logic [ADDR_W-1:0] target, target_q, off_ext;
  logic [DATA_W-1:0] opnd_a, opnd_b;

  assign opnd_a  = bus.rdata1;
  assign opnd_b  = bus.rdata2;
  assign taken   = bus.br_is_bne ? (opnd_a != opnd_b) : (opnd_a == opnd_b);
  assign off_ext = {{(ADDR_W-18){bus.br_offset[15]}}, bus.br_offset, 2'b00};
  assign target  = bus.br_pc + ADDR_W'(4) + off_ext;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (latch) begin
        taken_q  <= taken;
        target_q <= target;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    latch        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.br_valid) begin
          if (bus.opnd_ready) begin
            latch     = 1'b1;
            state_nxt = RESOLVE;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = '0;
          end
        end
      end
      WAIT: begin
        wait_cnt_nxt = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
        // A flushed branch must not latch whatever operands happen to be present.
        if (!bus.br_valid) begin
          state_nxt = IDLE;
        end else if (bus.opnd_ready) begin
          latch     = 1'b1;
          state_nxt = RESOLVE;
        end
      end
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.stall       = bus.br_valid & (state != RESOLVE);
  assign bus.br_ready    = (state == RESOLVE);
  assign bus.redirect    = (state == RESOLVE) & taken_q;
  assign bus.redirect_pc = target_q;
  assign bus.wait_err    = (state == WAIT) && (wait_cnt == MAX_W);

`ifdef BR_STAT_EN
  logic [31:0] br_cnt_q, taken_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (bus.br_ready) br_cnt_q    <= br_cnt_q + 32'd1;
      if (bus.redirect) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;
`endif

endmodule
